// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
package vram_pkg;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_VGA,
      GNT_DMA
   } gnt_t;

   localparam logic [2:0]  VGA_BASE_DEFAULT = 3'b110;
   localparam int unsigned WAIT_W           = 4;

endpackage

// File: rtl/vram_grant.sv
// Shared-slot priority decision: VGA first, DMA once it has been denied
// DMA_MAX_WAIT consecutive shared slots.
module vram_grant
   import vram_pkg::*;
#(
   parameter int unsigned DMA_MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic slot,
   input  logic vga_req,
   input  logic dma_req,
   output gnt_t gnt
);

   localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(DMA_MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt;

   always_comb begin
      gnt = GNT_IDLE;
      if (slot) begin
         if (vga_req && ((wait_cnt < MAX_WAIT) || !dma_req))
            gnt = GNT_VGA;
         else if (dma_req)
            gnt = GNT_DMA;
      end
   end

   // Counts only denied shared slots; CPU slots leave it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (!dma_req || (gnt == GNT_DMA))
         wait_cnt <= '0;
      else if (slot && (wait_cnt < MAX_WAIT))
         wait_cnt <= wait_cnt + 1'b1;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slices one single-port VRAM between the CPU (odd phase) and
// VGA/DMA (even phase), with two-cycle read-return pipelines.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned DMA_MAX_WAIT = 8,
   parameter logic [2:0]  VGA_BASE     = VGA_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        cpu_clk,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dbw,
   input  logic        cpu_we,
   input  logic        cpu_sel,
   output logic [7:0]  cpu_rdata,
   input  logic        vga_req,
   input  logic [12:0] vga_addr,
   output logic        vga_valid,
   output logic [7:0]  vga_data,
   output logic        vga_miss,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic        dma_rvalid,
   output logic [7:0]  dma_rdata,
   output logic [7:0]  miss_count,
   output logic [15:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_dbw,
   input  logic [7:0]  ram_dbr
);

   logic ph;
   logic cpu_pend;
   logic vga_p1;
   logic miss_p1;
   logic dma_p1;
   logic we;
   gnt_t gnt;

   assign cpu_clk = ph;

   vram_grant #(
      .DMA_MAX_WAIT(DMA_MAX_WAIT)
   ) u_grant (
      .clk     (clk),
      .rst     (rst),
      .slot    (~ph & ~rst),
      .vga_req (vga_req),
      .dma_req (dma_req),
      .gnt     (gnt)
   );

   always_comb begin
      ram_addr = {VGA_BASE, vga_addr};
      ram_dbw  = '0;
      we       = 1'b0;
      dma_ack  = 1'b0;
      if (ph) begin
         ram_addr = cpu_addr;
         ram_dbw  = cpu_dbw;
         we       = cpu_we & cpu_sel;
      end else if (gnt == GNT_DMA) begin
         ram_addr = dma_addr;
         ram_dbw  = dma_wdata;
         we       = dma_we;
         dma_ack  = 1'b1;
      end
   end

   assign ram_we = we & ~rst;

   // Stage 1 marks the grant; stage 2 samples ram_dbr and raises the strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph         <= 1'b0;
         cpu_pend   <= 1'b0;
         cpu_rdata  <= '0;
         vga_p1     <= 1'b0;
         miss_p1    <= 1'b0;
         dma_p1     <= 1'b0;
         vga_valid  <= 1'b0;
         vga_miss   <= 1'b0;
         dma_rvalid <= 1'b0;
         vga_data   <= '0;
         dma_rdata  <= '0;
         miss_count <= '0;
      end else begin
         ph         <= ~ph;
         cpu_pend   <= ph;
         if (cpu_pend)
            cpu_rdata <= ram_dbr;
         vga_p1     <= (gnt == GNT_VGA);
         miss_p1    <= (gnt == GNT_DMA) && vga_req;
         dma_p1     <= (gnt == GNT_DMA) && !dma_we;
         vga_valid  <= vga_p1;
         vga_miss   <= miss_p1;
         dma_rvalid <= dma_p1;
         if (vga_p1)
            vga_data <= ram_dbr;
         if (dma_p1)
            dma_rdata <= ram_dbr;
         if (miss_p1 && (miss_count != '1))
            miss_count <= miss_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural
// read-first RAM attached to the ram_* port.
module tb_vram_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_clk;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dbw;
   logic        cpu_we;
   logic        cpu_sel;
   logic [7:0]  cpu_rdata;
   logic        vga_req;
   logic [12:0] vga_addr;
   logic        vga_valid;
   logic [7:0]  vga_data;
   logic        vga_miss;
   logic        dma_req;
   logic        dma_we;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_ack;
   logic        dma_rvalid;
   logic [7:0]  dma_rdata;
   logic [7:0]  miss_count;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_dbw;
   logic [7:0]  ram_dbr;

   int checks = 0;
   int errors = 0;

   logic       tb_ph;
   logic [7:0] mem [0:65535];
   bit         mem_ready = 1'b0;

   vram_arbiter #(
      .DMA_MAX_WAIT (8),
      .VGA_BASE     (3'b110)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_clk    (cpu_clk),
      .cpu_addr   (cpu_addr),
      .cpu_dbw    (cpu_dbw),
      .cpu_we     (cpu_we),
      .cpu_sel    (cpu_sel),
      .cpu_rdata  (cpu_rdata),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .vga_valid  (vga_valid),
      .vga_data   (vga_data),
      .vga_miss   (vga_miss),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_ack    (dma_ack),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .miss_count (miss_count),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_dbw    (ram_dbw),
      .ram_dbr    (ram_dbr)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Read-first RAM, preloaded on the first edge.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
         mem[16'hC005] <= 8'hA5;
         mem[16'h4000] <= 8'h3C;
         mem_ready <= 1'b1;
      end
      ram_dbr <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_dbw;
   end

   // Expected phase: 0 out of reset, toggling every edge.
   always @(posedge clk or posedge rst) begin
      if (rst) tb_ph <= 1'b0;
      else     tb_ph <= ~tb_ph;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      cpu_addr = '0; cpu_dbw = '0; cpu_we = 1'b0; cpu_sel = 1'b0;
      vga_req = 1'b0; vga_addr = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
   endtask

   task automatic wait_ph(input logic p);
      @(negedge clk);
      if (tb_ph !== p) @(negedge clk);
   endtask

   function automatic bit dma_gnt_at(input int c);
      return (c >= 0) && (c < 40) && (c % 2 == 0) && ((c / 2) % 9 == 8);
   endfunction

   function automatic bit vga_gnt_at(input int c);
      return (c >= 0) && (c < 40) && (c % 2 == 0) && !dma_gnt_at(c);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1234; dma_wdata = 8'hEE;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL rst_ph: got %b exp 0", cpu_clk); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b exp 0", ram_we); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_cpu_rdata: got %h exp 00", cpu_rdata); end
      checks++; if (miss_count !== 8'h00) begin errors++; $display("FAIL rst_miss_count: got %h exp 00", miss_count); end
      checks++; if ({vga_valid, vga_miss, dma_rvalid} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b exp 000", {vga_valid, vga_miss, dma_rvalid}); end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      #1;
      checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL rel_first_slot: got %b exp 0", cpu_clk); end
      @(negedge clk); #1;
      checks++; if (cpu_clk !== 1'b1) begin errors++; $display("FAIL rel_second_slot: got %b exp 1", cpu_clk); end
   endtask

   task automatic test_cpu();
      idle_inputs();
      wait_ph(1'b1);
      cpu_addr = 16'h0123; cpu_dbw = 8'h5A; cpu_we = 1'b1; cpu_sel = 1'b1;
      #1;
      checks++; if (cpu_clk !== 1'b1) begin errors++; $display("FAIL cpu_phase: got %b exp 1", cpu_clk); end
      checks++; if (ram_addr !== 16'h0123) begin errors++; $display("FAIL cpu_wr_addr: got %h exp 0123", ram_addr); end
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL cpu_wr_we: got %b exp 1", ram_we); end
      checks++; if (ram_dbw !== 8'h5A) begin errors++; $display("FAIL cpu_wr_dbw: got %h exp 5a", ram_dbw); end
      @(negedge clk);
      cpu_we = 1'b0; cpu_sel = 1'b0;
      #1;
      checks++; if (ram_addr !== 16'hC000) begin errors++; $display("FAIL idle_addr: got %h exp c000", ram_addr); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b exp 0", ram_we); end
      @(negedge clk);
      cpu_sel = 1'b1;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL cpu_rd_we: got %b exp 0", ram_we); end
      @(negedge clk); #1;
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL cpu_rdata_hold: got %h exp 00", cpu_rdata); end
      @(negedge clk);
      cpu_sel = 1'b0; cpu_we = 1'b1; cpu_dbw = 8'hFF;
      #1;
      checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL cpu_rdata: got %h exp 5a", cpu_rdata); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL cpu_nosel_we: got %b exp 0", ram_we); end
      checks++; if (ram_addr !== 16'h0123) begin errors++; $display("FAIL cpu_nosel_addr: got %h exp 0123", ram_addr); end
      @(negedge clk);
      cpu_we = 1'b0;
      @(negedge clk);
      cpu_sel = 1'b1;
      @(negedge clk);
      @(negedge clk); #1;
      checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL cpu_nosel_nowrite: got %h exp 5a", cpu_rdata); end
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_vga_stream();
      bit exp_v;
      idle_inputs();
      wait_ph(1'b0);
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         vga_req = (c < 10); vga_addr = 13'h0005;
         #1;
         if (c % 2 == 0) begin
            checks++; if (ram_addr !== 16'hC005) begin errors++; $display("FAIL vga_addr c=%0d: got %h exp c005", c, ram_addr); end
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL vga_we c=%0d: got %b exp 0", c, ram_we); end
         end
         exp_v = vga_gnt_at(c - 2) && (c - 2 < 10);
         checks++; if (vga_valid !== exp_v) begin errors++; $display("FAIL vga_valid c=%0d: got %b exp %b", c, vga_valid, exp_v); end
         if (exp_v) begin
            checks++; if (vga_data !== 8'hA5) begin errors++; $display("FAIL vga_data c=%0d: got %h exp a5", c, vga_data); end
         end
      end
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_dma_write();
      idle_inputs();
      wait_ph(1'b1);
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hD000; dma_wdata = 8'h77;
      #1;
      checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_cpu_slot: got %b exp 0", dma_ack); end
      checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL dma_cpu_slot_addr: got %h exp 0000", ram_addr); end
      @(negedge clk); #1;
      checks++; if (dma_ack !== 1'b1) begin errors++; $display("FAIL dma_ack: got %b exp 1", dma_ack); end
      checks++; if (ram_addr !== 16'hD000) begin errors++; $display("FAIL dma_addr: got %h exp d000", ram_addr); end
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL dma_we: got %b exp 1", ram_we); end
      checks++; if (ram_dbw !== 8'h77) begin errors++; $display("FAIL dma_dbw: got %h exp 77", ram_dbw); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_once: got %b exp 0", dma_ack); end
      @(negedge clk);
      vga_req = 1'b1; vga_addr = 13'h1000;
      #1;
      checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL dma_wr_rvalid: got %b exp 0", dma_rvalid); end
      checks++; if (ram_addr !== 16'hD000) begin errors++; $display("FAIL vga_fetch_addr: got %h exp d000", ram_addr); end
      @(negedge clk);
      vga_req = 1'b0;
      @(negedge clk); #1;
      checks++; if (vga_valid !== 1'b1) begin errors++; $display("FAIL vga_fetch_valid: got %b exp 1", vga_valid); end
      checks++; if (vga_data !== 8'h77) begin errors++; $display("FAIL vga_fetch_data: got %h exp 77", vga_data); end
      @(negedge clk); #1;
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL vga_valid_once: got %b exp 0", vga_valid); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_starvation();
      bit exp_ack, exp_v, exp_m;
      int exp_mc;
      idle_inputs();
      wait_ph(1'b0);
      for (int c = 0; c < 42; c++) begin
         if (c > 0) @(negedge clk);
         vga_req = (c < 40); vga_addr = 13'h0005;
         dma_req = (c < 40); dma_we = 1'b0; dma_addr = 16'h4000;
         #1;
         exp_ack = dma_gnt_at(c);
         exp_v   = vga_gnt_at(c - 2);
         exp_m   = dma_gnt_at(c - 2);
         exp_mc  = 0;
         if (c >= 18) exp_mc++;
         if (c >= 36) exp_mc++;
         checks++; if (dma_ack !== exp_ack) begin errors++; $display("FAIL st_ack c=%0d: got %b exp %b", c, dma_ack, exp_ack); end
         checks++; if (vga_valid !== exp_v) begin errors++; $display("FAIL st_vvalid c=%0d: got %b exp %b", c, vga_valid, exp_v); end
         checks++; if (vga_miss !== exp_m) begin errors++; $display("FAIL st_miss c=%0d: got %b exp %b", c, vga_miss, exp_m); end
         checks++; if (dma_rvalid !== exp_m) begin errors++; $display("FAIL st_rvalid c=%0d: got %b exp %b", c, dma_rvalid, exp_m); end
         checks++; if (miss_count !== 8'(exp_mc)) begin errors++; $display("FAIL st_miss_count c=%0d: got %0d exp %0d", c, miss_count, exp_mc); end
         if (exp_ack) begin
            checks++; if (ram_addr !== 16'h4000) begin errors++; $display("FAIL st_dma_addr c=%0d: got %h exp 4000", c, ram_addr); end
         end
         if (exp_m) begin
            checks++; if (dma_rdata !== 8'h3C) begin errors++; $display("FAIL st_dma_rdata c=%0d: got %h exp 3c", c, dma_rdata); end
         end
         if (exp_v) begin
            checks++; if (vga_data !== 8'hA5) begin errors++; $display("FAIL st_vga_data c=%0d: got %h exp a5", c, vga_data); end
         end
      end
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturation();
      idle_inputs();
      wait_ph(1'b0);
      vga_req = 1'b1; vga_addr = 13'h0005;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h4000;
      repeat (1800) @(negedge clk);
      #1;
      checks++; if (miss_count !== 8'd102) begin errors++; $display("FAIL sat_mid: got %0d exp 102", miss_count); end
      repeat (3600) @(negedge clk);
      #1;
      checks++; if (miss_count !== 8'd255) begin errors++; $display("FAIL sat_max: got %0d exp 255", miss_count); end
      repeat (36) @(negedge clk);
      #1;
      checks++; if (miss_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d exp 255", miss_count); end
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      idle_inputs();
      cpu_addr = 16'h0123; cpu_sel = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL pre_rst_rdata: got %h exp 5a", cpu_rdata); end
      idle_inputs();
      wait_ph(1'b0);
      vga_req = 1'b1; vga_addr = 13'h0005;
      @(negedge clk);
      vga_req = 1'b0;
      rst = 1'b1;
      cpu_we = 1'b1; cpu_sel = 1'b1;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b exp 0", ram_we); end
      checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL mid_rst_ph: got %b exp 0", cpu_clk); end
      checks++; if (miss_count !== 8'h00) begin errors++; $display("FAIL mid_rst_miss_count: got %0d exp 0", miss_count); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL mid_rst_rdata: got %h exp 00", cpu_rdata); end
      @(negedge clk); #1;
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_vvalid: got %b exp 0", vga_valid); end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      #1;
      checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL mid_rel_ph: got %b exp 0", cpu_clk); end
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL mid_rel_vvalid: got %b exp 0", vga_valid); end
      @(negedge clk); #1;
      checks++; if (cpu_clk !== 1'b1) begin errors++; $display("FAIL mid_rel_ph2: got %b exp 1", cpu_clk); end
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL mid_rel_vvalid2: got %b exp 0", vga_valid); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_cpu();
      test_vga_stream();
      test_dma_write();
      test_starvation();
      test_saturation();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter DMA_MAX_WAIT, default 8, is the number of consecutive denied shared slots after which DMA wins over VGA.
REQ-002 Parameter VGA_BASE, default 3'b110, supplies the upper three bits prepended to VGA addresses (range $C000-$DFFF).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  main 25.175MHz clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cpu_clk  out  1  phase bit; equals 1 during a CPU slot.
REQ-007 cpu_addr/cpu_dbw/cpu_we/cpu_sel  in  16/8/1/1  CPU bus; cpu_sel is RAM chip select.
REQ-008 cpu_rdata  out  8  registered CPU read data.
REQ-009 vga_req/vga_addr  in  1/13  VGA fetch request and address.
REQ-010 vga_valid/vga_data/vga_miss  out  1/8/1  VGA read-return strobe, data, and denied-fetch pulse.
REQ-011 dma_req/dma_we/dma_addr/dma_wdata  in  1/1/16/8  DMA request port.
REQ-012 dma_ack/dma_rvalid/dma_rdata  out  1/1/8  DMA grant, read-return strobe, and read data.
REQ-013 miss_count  out  8  saturating count of VGA misses.
REQ-014 ram_addr/ram_we/ram_dbw  out  16/1/8  single-port RAM drive.
REQ-015 ram_dbr  in  8  RAM read data, valid the cycle after its address was presented.

Function
REQ-016 Phase register ph SHALL toggle every clk; cpu_clk = ph.
REQ-017 CPU slot (ph=1) SHALL drive ram_addr=cpu_addr, ram_dbw=cpu_dbw, ram_we=cpu_we&cpu_sel; no other requester is ever served in this slot.
REQ-018 cpu_rdata SHALL capture ram_dbr at the end of the cycle following a CPU slot, and hold it otherwise.
REQ-019 Shared slot (ph=0) grant: if vga_req and (wait<DMA_MAX_WAIT or !dma_req), grant VGA; else if dma_req, grant DMA; else idle.
REQ-020 VGA grant at cycle T SHALL drive ram_addr={VGA_BASE,vga_addr}, ram_we=0; vga_valid SHALL be high for exactly cycle T+2, with vga_data=ram_dbr sampled at T+1.
REQ-021 DMA grant at cycle T SHALL drive ram_addr=dma_addr, ram_dbw=dma_wdata, ram_we=dma_we, and assert dma_ack combinationally in T only.
REQ-022 A DMA read granted at T SHALL raise dma_rvalid for exactly cycle T+2 with dma_rdata; writes produce no dma_rvalid.
REQ-023 The requester SHALL hold dma_req/dma_addr/dma_we/dma_wdata stable until dma_ack; the arbiter does not queue.
REQ-024 wait counter (4 bits): increments on each shared slot where dma_req is high and not granted, saturating at DMA_MAX_WAIT; clears on DMA grant or when dma_req is low.
REQ-025 When DMA wins while vga_req is high, vga_miss SHALL pulse in T+2 in place of vga_valid, and miss_count SHALL increment, saturating at 255.
REQ-026 Idle shared slot: ram_we=0, ram_addr={VGA_BASE,vga_addr}, no strobes.
REQ-027 A CPU slot with cpu_sel=0 SHALL still present cpu_addr with ram_we=0; cpu_rdata updates harmlessly.

Reset
REQ-028 On rst: ph=0, wait=0, miss_count=0, cpu_rdata=0, and vga_valid/vga_miss/dma_rvalid=0 with in-flight returns discarded; ram_we SHALL be 0 while rst is high.
REQ-029 The first shared slot after reset release SHALL be the first clk edge with ph=0.

Structure
REQ-030 Package vram_pkg SHALL hold the grant enum {GNT_IDLE, GNT_VGA, GNT_DMA}, the VGA_BASE default, and the wait-counter width.
REQ-031 Sub-module vram_grant SHALL contain the priority decision and the starvation counter; the top level contains the phase logic, muxing, and return pipelines.

Verification
REQ-032 CPU write $0123=$5A then read $0123 -> cpu_rdata=$5A one cycle after the read slot.
REQ-033 vga_req with vga_addr=$0005 continuous, no DMA -> ram_addr=$C005 every shared slot, and vga_valid every other cycle.
REQ-034 VGA and DMA read both continuous, DMA_MAX_WAIT=8 -> DMA granted on every 9th shared slot, vga_miss pulses in step, and miss_count increments by 1 each time.
REQ-035 DMA write $D000=$77 with VGA idle -> dma_ack in the first shared slot; a later VGA fetch of $1000 returns $77.
REQ-036 Assert rst in the cycle after a VGA grant -> no vga_valid, outputs return to reset values, and ph=0 after release.
REQ-037 Force 300 misses -> miss_count=255 and holds at 255.
